// File: rtl/message_serializer.sv
// Bit-serial laser framer: fetches buffer words 1..maxaddr and sends each as PREAMBLE + word.
// Optional even-parity bit after each word when SERIALIZER_PARITY_EN is defined.
module message_serializer #(
  parameter int         LOGSIZE    = 10,
  parameter int         WIDTH      = 64,
  parameter int         BIT_PERIOD = 100,
  parameter logic [7:0] PREAMBLE   = 8'hAB
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LOGSIZE-1:0] maxaddr,
  output logic [LOGSIZE-1:0] readaddr,
  input  logic [WIDTH-1:0]   din,
  output logic               laser_out,
  output logic               busy,
  output logic               done
);

  localparam int PCNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int BCNT_W = $clog2((WIDTH > 8) ? WIDTH : 8);
  localparam logic [PCNT_W-1:0] PER_LAST  = PCNT_W'(BIT_PERIOD - 1);
  localparam logic [BCNT_W-1:0] PRE_LAST  = BCNT_W'(7);
  localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, PRE, DATA, PAR, NEXT, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, PRE, DATA, NEXT, DONE
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [LOGSIZE-1:0]   addr_q, addr_d;
  logic [LOGSIZE-1:0]   max_q, max_d;
  logic [LOGSIZE-1:0]   readaddr_q, readaddr_d;
  logic [PCNT_W-1:0]    per_q, per_d;
  logic [BCNT_W-1:0]    bit_q, bit_d;
  logic                 laser_q, laser_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [7:0]           pre_q, pre_d;
`ifdef SERIALIZER_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 per_last;

  assign per_last = (per_q == PER_LAST);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    max_d      = max_q;
    readaddr_d = readaddr_q;
    per_d      = per_q;
    bit_d      = bit_q;
    laser_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    pre_d      = pre_q;
`ifdef SERIALIZER_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          max_d  = maxaddr;
          addr_d = LOGSIZE'(1);
          if (maxaddr == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = FETCH;
            busy_d     = 1'b1;
            readaddr_d = LOGSIZE'(1);
          end
        end
      end

      // Buffer read port registers readaddr this cycle; din is valid in LATCH.
      FETCH: state_d = LATCH;

      LATCH: begin
        shift_d = din;
        pre_d   = PREAMBLE;
`ifdef SERIALIZER_PARITY_EN
        par_d   = ^din;
`endif
        per_d   = '0;
        bit_d   = '0;
        state_d = PRE;
      end

      // laser_out is registered, so each bit shows one clock after its state cycle.
      PRE: begin
        laser_d = pre_q[7];
        per_d   = per_q + PCNT_W'(1);
        if (per_last) begin
          per_d = '0;
          pre_d = {pre_q[6:0], 1'b0};
          if (bit_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = DATA;
          end else begin
            bit_d = bit_q + BCNT_W'(1);
          end
        end
      end

      DATA: begin
        laser_d = shift_q[WIDTH-1];
        per_d   = per_q + PCNT_W'(1);
        if (per_last) begin
          per_d   = '0;
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d = PAR;
`else
            state_d = NEXT;
`endif
          end else begin
            bit_d = bit_q + BCNT_W'(1);
          end
        end
      end

`ifdef SERIALIZER_PARITY_EN
      PAR: begin
        laser_d = par_q;
        per_d   = per_q + PCNT_W'(1);
        if (per_last) begin
          per_d   = '0;
          state_d = NEXT;
        end
      end
`endif

      NEXT: begin
        if (addr_q == max_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          addr_d     = addr_q + LOGSIZE'(1);
          readaddr_d = addr_q + LOGSIZE'(1);
          state_d    = FETCH;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    pre_q   <= pre_d;
`ifdef SERIALIZER_PARITY_EN
    par_q   <= par_d;
`endif
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      max_q      <= '0;
      readaddr_q <= '0;
      per_q      <= '0;
      bit_q      <= '0;
      laser_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      max_q      <= max_d;
      readaddr_q <= readaddr_d;
      per_q      <= per_d;
      bit_q      <= bit_d;
      laser_q    <= laser_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign readaddr  = readaddr_q;
  assign laser_out = laser_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_message_serializer.sv
// Scoreboard bench for message_serializer: per-clock expected waveform from a frame-level model.
module tb_message_serializer;

  localparam int LOGSIZE = 4;
  localparam int WIDTH   = 16;
  localparam int P       = 2;
`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = 8 + WIDTH + 1;
`else
  localparam int NBITS = 8 + WIDTH;
`endif

  typedef struct {
    logic laser;
    logic busy;
    logic done;
    int   raddr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b1;
  logic [LOGSIZE-1:0] maxaddr = '0;
  logic [LOGSIZE-1:0] readaddr;
  logic [WIDTH-1:0]   din = '0;
  logic               laser_out;
  logic               busy;
  logic               done;

  logic [WIDTH-1:0] mem [16];
  exp_t exp_q[$];
  exp_t run_q[$];
  int   done_idx;
  int   errors = 0;
  int   checks = 0;

  message_serializer #(
    .LOGSIZE(LOGSIZE), .WIDTH(WIDTH), .BIT_PERIOD(P), .PREAMBLE(8'hAB)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .maxaddr(maxaddr),
    .readaddr(readaddr), .din(din), .laser_out(laser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Buffer model: registered read port, one clock of latency.
  always @(posedge clk) din <= mem[readaddr];

  // Monitor: one expected sample per clock while the scoreboard holds entries.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (laser_out !== e.laser) begin
        errors++;
        $display("FAIL laser_out @%0t: got %0b want %0b", $time, laser_out, e.laser);
      end
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy @%0t: got %0b want %0b", $time, busy, e.busy);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("FAIL done @%0t: got %0b want %0b", $time, done, e.done);
      end
      if (e.raddr >= 0) begin
        checks++;
        if (int'(readaddr) != e.raddr) begin
          errors++;
          $display("FAIL readaddr @%0t: got %0d want %0d", $time, readaddr, e.raddr);
        end
      end
    end
  end

  function automatic exp_t mk(logic l, logic b, logic d, int r);
    exp_t e;
    e.laser = l; e.busy = b; e.done = d; e.raddr = r;
    return e;
  endfunction

  // Expected clock-by-clock outputs for a run over words 1..m, starting the cycle before start is sampled.
  task automatic build_run(input int m);
    logic [7:0]       pre;
    logic [WIDTH-1:0] w;
    int               bits[$];
    pre = 8'hAB;
    run_q.delete();
    run_q.push_back(mk(1'b0, 1'b0, 1'b0, -1));
    for (int a = 1; a <= m; a++) begin
      w = mem[a];
      bits.delete();
      for (int i = 7; i >= 0; i--) bits.push_back(int'(pre[i]));
      for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(int'(w[i]));
`ifdef SERIALIZER_PARITY_EN
      bits.push_back($countones(w) % 2);
`endif
      for (int g = 0; g < 3; g++) run_q.push_back(mk(1'b0, 1'b1, 1'b0, a));
      foreach (bits[k])
        for (int t = 0; t < P; t++) run_q.push_back(mk(bits[k][0], 1'b1, 1'b0, a));
    end
    done_idx = run_q.size();
    run_q.push_back(mk(1'b0, 1'b0, 1'b1, (m > 0) ? m : -1));
    for (int g = 0; g < 3; g++) run_q.push_back(mk(1'b0, 1'b0, 1'b0, -1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d samples left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Drive one run. start_inj/rst_at/max_at are cycle offsets after the start edge (-1 = unused).
  task automatic run(input int m, input int start_inj, input int max_at, input int max_val,
                     input int rst_at);
    int len;
    drain();
    build_run(m);
    if (rst_at >= 0) begin
      while (run_q.size() > rst_at + 2) void'(run_q.pop_back());
      for (int g = 0; g < 4; g++) run_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    end
    len = run_q.size();
    @(posedge clk);
    #1;
    start   = 1'b1;
    maxaddr = LOGSIZE'(m);
    foreach (run_q[i]) exp_q.push_back(run_q[i]);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      start = (c == start_inj);
      reset = (c == rst_at);
      if (c == max_at) maxaddr = LOGSIZE'(max_val);
    end
    start = 1'b0;
    reset = 1'b0;
    drain();
  endtask

  initial begin
    int m;
    for (int i = 0; i < 16; i++) mem[i] = WIDTH'(i * 16'h1111);
    // Reset held with start asserted
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 0));
    drain();

    mem[1] = 16'hA5C3;
    run(1, -1, -1, 0, -1);

    mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
    run(3, -1, -1, 0, -1);

    run(0, -1, -1, 0, -1);

    // start during DATA ignored; maxaddr changed mid-run ignored
    run(3, 25, 10, 1, -1);
    run(2, 40, 5, 7, -1);

    mem[1] = 16'h0003;
    build_run(1);
    run(1, done_idx - 1, -1, 0, -1);

    run(2, -1, -1, 0, 30);

    for (int r = 0; r < 6; r++) begin
      m = int'($urandom_range(1, 4));
      for (int a = 1; a <= m; a++) mem[a] = WIDTH'($urandom);
      run(m, int'($urandom_range(20, 45)), int'($urandom_range(2, 40)),
          int'($urandom_range(0, 15)), (r == 5) ? int'($urandom_range(22, 50)) : -1);
    end

    run(1, -1, -1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
